// File: rtl/mem_arbiter.sv
// Shared word memory for fetch and data channels; data beats fetch on a tie.
// Latency: ready pulses LATENCY+1 cycles after acceptance. Backpressure: the core holds req and sees stall until ready.
// Accesses are strictly serialised (IDLE -> BUSY -> DONE), so no forwarding is needed.
module mem_arbiter #(
    parameter int W        = 32,
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 2,
    parameter int ADDR_LSB = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_req,
    input  logic [W-1:0]   i_addr,
    output logic [W-1:0]   i_data,
    output logic           i_ready,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [W-1:0]   d_addr,
    input  logic [W-1:0]   d_wdata,
    input  logic [W/8-1:0] d_be,
    output logic [W-1:0]   d_rdata,
    output logic           d_ready,
    output logic           stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = W / 8;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          sel_d;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [W-1:0]  wdata_q;
    logic [NB-1:0] be_q;
    logic [W-1:0]  mem [DEPTH];

    logic accept;
    logic access;
    logic unused_addr_bits;

    assign accept = (state == IDLE) && (i_req || d_req);
    assign access = (state == BUSY) && (cnt == '0);
    assign stall  = (i_req && !i_ready) || (d_req && !d_ready);

    // Only the index field of each address is meaningful; the rest wraps away.
    assign unused_addr_bits = ^{i_addr, d_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_d   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            i_data  <= '0;
            d_rdata <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel_d   <= d_req;
                        we_q    <= d_req && d_we;
                        idx_q   <= d_req ? d_addr[ADDR_LSB +: AW] : i_addr[ADDR_LSB +: AW];
                        wdata_q <= d_wdata;
                        be_q    <= d_be;
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (access) begin
                        state <= DONE;
                        if (sel_d) begin
                            d_rdata <= mem[idx_q];
                            d_ready <= 1'b1;
                        end else begin
                            i_data  <= mem[idx_q];
                            i_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; a store caught by reset never commits.
    always_ff @(posedge clk) begin
        if (access && we_q && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus tie, reset and LATENCY=1 sequences.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] i_data, d_rdata;
    logic        i_ready, d_ready, stall;

    logic        i1_req = 1'b0;
    logic [31:0] i1_addr = '0;
    logic [31:0] i1_data, d1_rdata;
    logic        i1_ready, d1_ready, stall1;
    logic        d1_req = 1'b0, d1_we = 1'b0;
    logic [31:0] d1_addr = '0, d1_wdata = '0;
    logic [3:0]  d1_be = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.W(32), .DEPTH(1024), .LATENCY(2), .ADDR_LSB(2)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall)
    );

    mem_arbiter #(.W(32), .DEPTH(16), .LATENCY(1), .ADDR_LSB(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i1_req), .i_addr(i1_addr), .i_data(i1_data), .i_ready(i1_ready),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata), .d_be(d1_be),
        .d_rdata(d1_rdata), .d_ready(d1_ready), .stall(stall1)
    );

    typedef struct {
        logic        dsel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One access from IDLE; returns data, edges until ready (99 = timeout) and stall cycles seen.
    task automatic txn(input logic dsel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] data, output int lat, output int st);
        i_addr = addr; d_addr = addr; d_we = we; d_wdata = wdata; d_be = be;
        if (dsel) d_req = 1'b1; else i_req = 1'b1;
        lat = 99; st = 0; data = '0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (stall) st++;
            @(posedge clk); #1;
            if (dsel ? d_ready : i_ready) begin
                lat  = n;
                data = dsel ? d_rdata : i_data;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t        vecs [12];
    logic [31:0] data;
    int          lat, st;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0014, 32'h1122_3344, 4'h5, 1'b1, 32'hAABB_CCDD};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         4'h0, 1'b1, 32'hAA22_CC44};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_100C, 32'h5566_7788, 4'hF, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         4'h0, 1'b1, 32'h5566_7788};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_100C, 32'h0,         4'h0, 1'b1, 32'h5566_7788};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0123_4567, 4'hF, 1'b0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall",   {31'b0, stall},   32'h0);
        check("reset_i_ready", {31'b0, i_ready}, 32'h0);
        check("reset_d_ready", {31'b0, d_ready}, 32'h0);
        check("reset_d_rdata", d_rdata, 32'h0);
        check("reset_i_data",  i_data,  32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 12; v++) begin
            txn(vecs[v].dsel, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be, data, lat, st);
            check($sformatf("vec%0d_latency", v), lat, 32'd3);
            check($sformatf("vec%0d_stall_cycles", v), st, 32'd3);
            if (vecs[v].chk) check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
        end

        // Data load and fetch raised together: data wins, fetch follows one IDLE later.
        begin
            int d_at = 99, i_at = 99;
            logic [31:0] dv = '0, iv = '0;
            i_addr = 32'h0; d_addr = 32'h10; d_we = 1'b0;
            i_req = 1'b1; d_req = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (d_ready) begin d_at = c; dv = d_rdata; d_req = 1'b0; end
                if (i_ready) begin i_at = c; iv = i_data;  i_req = 1'b0; end
            end
            i_req = 1'b0; d_req = 1'b0;
            check("tie_d_ready_at", d_at, 32'd3);
            check("tie_d_rdata",    dv,   32'hCAFE_F00D);
            check("tie_i_ready_at", i_at, 32'd7);
            check("tie_i_data",     iv,   32'h0123_4567);
        end

        // Reset while a store is in BUSY: nothing commits and outputs clear.
        begin
            int pulses = 0;
            d_addr = 32'h14; d_we = 1'b1; d_wdata = 32'hFFFF_FFFF; d_be = 4'hF;
            d_req = 1'b1;
            @(posedge clk); #1;
            rst = 1'b1; d_req = 1'b0;
            #1;
            check("rst_busy_stall",   {31'b0, stall},   32'h0);
            check("rst_busy_d_ready", {31'b0, d_ready}, 32'h0);
            check("rst_busy_d_rdata", d_rdata, 32'h0);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (d_ready || i_ready) pulses++;
            end
            check("rst_busy_no_pulse", pulses, 32'd0);
            rst = 1'b0;
            @(posedge clk); #1;
            txn(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, data, lat, st);
            check("rst_store_dropped", data, 32'hAA22_CC44);
        end

        // LATENCY=1 instance under continuous fetch: one pulse every third cycle.
        begin
            int pulses = 0, bad = 0, prev = -1, first = -1;
            i1_req = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                @(posedge clk); #1;
                if (i1_ready) begin
                    pulses++;
                    if (first < 0) first = c;
                    if (prev >= 0 && c - prev != 3) bad++;
                    prev = c;
                end
            end
            i1_req = 1'b0;
            check("lat1_first_pulse", first,  32'd2);
            check("lat1_pulse_count", pulses, 32'd10);
            check("lat1_bad_spacing", bad,    32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
